div_8bit_seq: RTL

//   Multi-cycle unsigned restoring divider: the subtract-side counterpart of the

---
 rtl/div_8bit_seq_pkg.sv | 13 +
 rtl/div_8bit_seq_sub.sv | 25 ++
 rtl/div_8bit_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/div_8bit_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_8bit_seq_pkg;

  localparam int DIV_WIDTH = 8;

  // Encoding 2'd3 is unused and falls back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/div_8bit_seq_sub.sv
// Ripple subtractor a - b built as a + ~b + 1; borrow is the inverted carry-out.
module div_8bit_seq_sub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] carry;

  // Full-adder chain with the +1 injected as the initial carry.
  always_comb begin
    carry    = '0;
    diff     = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i]      = a[i] ^ ~b[i] ^ carry[i];
      carry[i + 1] = (a[i] & ~b[i]) | (a[i] & carry[i]) | (~b[i] & carry[i]);
    end
    borrow = ~carry[WIDTH];
  end

endmodule

// File: rtl/div_8bit_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on the accepting edge
// S_RUN  | shift and trial-subtract, WIDTH iterations
// S_FIN  | one cycle: done pulse, results already visible
module div_8bit_seq
  import div_8bit_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_work, r_work, d_work;
  logic [WIDTH-1:0] r_sh, q_sh, q_nxt, r_nxt;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             unused_bits;

  // One iteration: shift {r,q} left, then try r - d.
  assign r_sh = {r_work[WIDTH-2:0], q_work[WIDTH-1]};
  assign q_sh = {q_work[WIDTH-2:0], 1'b0};

  div_8bit_seq_sub #(.WIDTH(WIDTH + 1)) u_sub (
    .a      ({1'b0, r_sh}),
    .b      ({1'b0, d_work}),
    .diff   (trial),
    .borrow (borrow)
  );

  assign q_nxt = {q_sh[WIDTH-1:1], ~borrow};
  assign r_nxt = borrow ? r_sh : trial[WIDTH-1:0];

  // The partial remainder is always below 2^(WIDTH-1) before a shift that
  // can still matter, so its MSB and the trial MSB never carry information.
  assign unused_bits = ^{trial[WIDTH], r_work[WIDTH-1]};

  assign busy = (state == S_RUN) || (state == S_FIN);
  assign done = (state == S_FIN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (divisor == '0) ? S_FIN : S_RUN;
      S_RUN:  if (count == CW'(1)) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Working registers; results load on the edge entering S_FIN so they are
  // already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      q_work      <= '0;
      r_work      <= '0;
      d_work      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            q_work <= dividend;
            d_work <= divisor;
            r_work <= '0;
            count  <= CW'(WIDTH);
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          q_work <= q_nxt;
          r_work <= r_nxt;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
